// File: rtl/icache_line_adaptor.sv
// icache_line_adaptor: fills a 256-bit I-cache line from four 64-bit memory beats and drains a line back out as four beats.
// ICACHE_ADAPTOR_EARLY_RESP_EN: drop DONE and respond combinationally on the last beat.
module icache_line_adaptor #(
    parameter int s_offset = 5,
    parameter int s_line   = 8 * 2**s_offset,
    parameter int s_beat   = 64,
    parameter int n_beat   = s_line / s_beat
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       addr_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    output logic              resp_o,
    output logic [31:0]       mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [s_beat-1:0] mem_wdata_o,
    input  logic [s_beat-1:0] mem_rdata_i,
    input  logic              mem_resp_i
);
    localparam int cw = $clog2(n_beat);
    typedef enum logic [1:0] {idle, rd, wr, done} state_t;
`ifdef ICACHE_ADAPTOR_EARLY_RESP_EN
    localparam state_t after_last = idle;
`else
    localparam state_t after_last = done;
`endif
    state_t            state, state_nx;
    logic [cw-1:0]     count;
    logic [s_line-1:0] line_buf;
    logic [31:0]       addr_q;
    logic              busy, last;
    assign busy = state == rd || state == wr;
    assign last = busy && mem_resp_i && count == cw'(n_beat - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= idle;
        else      state <= state_nx;
    end
    always_comb begin
        state_nx = state == idle ? (write_i ? wr : read_i ? rd : idle) :
                   state == done ? idle :
                   last          ? after_last : state;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            line_buf <= '0;
            addr_q   <= '0;
        end else if (state == idle) begin
            if (write_i || read_i) begin
                addr_q <= {addr_i[31:s_offset], {s_offset{1'b0}}};
                count  <= '0;
            end
            if (write_i) line_buf <= line_i;
        end else if (busy && mem_resp_i) begin
            count <= count + 1'b1;
            if (state == rd) line_buf[count*s_beat +: s_beat] <= mem_rdata_i;
        end
    end
    assign mem_addr_o = addr_q;
    always_comb begin
        mem_read_o  = state == rd;
        mem_write_o = state == wr;
        mem_wdata_o = state == wr ? line_buf[count*s_beat +: s_beat] : '0;
`ifdef ICACHE_ADAPTOR_EARLY_RESP_EN
        resp_o = last;
        line_o = state == rd && last ? {mem_rdata_i, line_buf[s_line-s_beat-1:0]} : line_buf;
`else
        resp_o = state == done;
        line_o = line_buf;
`endif
    end
endmodule

// File: tb/tb_icache_line_adaptor.sv
// tb_icache_line_adaptor: table vectors, corner sequences and randomized bursts against a line-level model.
module tb_icache_line_adaptor;
    logic         clk = 0, rst = 1;
    logic [31:0]  addr_i = 0;
    logic         read_i = 0, write_i = 0, mem_resp_i = 0;
    logic [255:0] line_i = 0, line_o;
    logic         resp_o, mem_read_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [63:0]  mem_wdata_o, mem_rdata_i = 0;
    int checks = 0, errors = 0;
`ifdef ICACHE_ADAPTOR_EARLY_RESP_EN
    localparam int lat_extra = 0;
`else
    localparam int lat_extra = 1;
`endif

    icache_line_adaptor dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .read_i(read_i), .write_i(write_i),
        .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .mem_addr_o(mem_addr_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Acts as requester and memory for one transaction; the memory returns the
    // beats of data lowest-first and the bench expects the whole line at resp_o.
    task automatic run(input bit is_wr, input bit also_rd, input bit skip0,
                       input logic [31:0] a, input logic [31:0] exp_a, input logic [255:0] data,
                       input int stall0, input int drop_after, input bit rnd, output int respc);
        int beat = 0, stalls = stall0, lastc = -1, nresp = 0;
        logic [255:0] got_line = 0;
        bit go, busy;
        respc = -1;
        if (!skip0) begin
            @(negedge clk);
            addr_i = a; read_i = !is_wr || also_rd; write_i = is_wr; line_i = data; mem_resp_i = 0;
        end
        for (int c = 1; c <= 60 && (respc < 0 || c <= respc + 1); c++) begin
            @(negedge clk);
            if (respc >= 0) begin write_i = 0; read_i = also_rd; end
            if (drop_after >= 0 && beat >= drop_after) begin read_i = 0; write_i = 0; end
            busy = is_wr ? mem_write_o : mem_read_o;
            chk("busy", busy, beat < 4);
            chk("other_strobe", is_wr ? mem_read_o : mem_write_o, 0);
            if (busy) chk("mem_addr", mem_addr_o, exp_a);
            if (busy && is_wr) chk("wdata", mem_wdata_o, data[beat*64 +: 64]);
            go = busy && beat < 4 && stalls == 0 && !(rnd && $urandom_range(0, 2) == 0);
            if (busy && stalls > 0) stalls--;
            mem_resp_i = go;
            mem_rdata_i = go && !is_wr ? data[beat*64 +: 64] : {$urandom, $urandom};
            #1;
            if (resp_o) begin
                nresp++;
                if (respc < 0) begin respc = c; got_line = line_o; end
            end
            if (go) begin beat++; if (beat == 4) lastc = c; end
        end
        mem_resp_i = 0;
        chk("resp_count", nresp, 1);
        chk("resp_cycle", respc, lastc + lat_extra);
        if (!is_wr) chk("line", got_line, data);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_no_burst", {mem_read_o, mem_write_o, resp_o}, 0);
        end
    endtask

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
        int           stall0;
        logic [31:0]  exp_addr;
        int           exp_resp;
    } vec_t;

    initial begin
        vec_t v[4];
        int r;
        logic [255:0] d, d2;
        v[0] = '{0, 32'h0000_1234, {64'h4444444444444444, 64'h3333333333333333,
                 64'h2222222222222222, 64'h1111111111111111}, 0, 32'h0000_1220, 4 + lat_extra};
        v[1] = '{1, 32'h8000_0047, {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                 64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA}, 3, 32'h8000_0040, 7 + lat_extra};
        v[2] = '{0, 32'hFFFF_FFFF, {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                 64'hA5A5A5A55A5A5A5A, 64'h00000000FFFFFFFF}, 1, 32'hFFFF_FFE0, 5 + lat_extra};
        v[3] = '{1, 32'h0000_001F, {64'h1, 64'h2, 64'h3, 64'h4}, 0, 32'h0, 4 + lat_extra};

        #1 rst = 0;
        #1;
        chk("reset_outputs", {line_o, resp_o, mem_read_o, mem_write_o}, 0);
        chk("reset_addr_wdata", {mem_addr_o, mem_wdata_o}, 0);
        @(negedge clk) rst = 1;

        for (int i = 0; i < 4; i++) begin
            run(v[i].wr, 0, 0, v[i].addr, v[i].exp_addr, v[i].data, v[i].stall0, -1, 0, r);
            chk("table_resp_cycle", r, v[i].exp_resp);
        end

        // Reset in the middle of a read after two beats.
        @(negedge clk); addr_i = 32'h40; read_i = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_resp_i = 1; mem_rdata_i = {$urandom, $urandom};
        end
        @(negedge clk); mem_resp_i = 0; read_i = 0; rst = 0;
        #1;
        chk("midrd_reset_outputs", {line_o, resp_o, mem_read_o, mem_write_o}, 0);
        chk("midrd_reset_addr_wdata", {mem_addr_o, mem_wdata_o}, 0);
        @(negedge clk) rst = 1;
        d = {64'h8888, 64'h7777, 64'h6666, 64'h5555};
        run(0, 0, 0, 32'h0000_0044, 32'h0000_0040, d, 0, -1, 0, r);
        chk("post_reset_resp_cycle", r, 4 + lat_extra);

        // Read and write together: write burst first, then the held read.
        d  = {64'hD0D0, 64'hC0C0, 64'hB0B0, 64'hA0A0};
        d2 = {64'h4040, 64'h3030, 64'h2020, 64'h1010};
        run(1, 1, 0, 32'h0000_2010, 32'h0000_2000, d, 0, -1, 0, r);
        run(0, 0, 1, 32'h0000_2010, 32'h0000_2000, d2, 0, -1, 0, r);
        chk("followup_read_resp_cycle", r, 4 + lat_extra);

        // Read dropped after the first beat still completes exactly once.
        run(0, 0, 0, 32'h0000_0300, 32'h0000_0300, d2, 0, 1, 0, r);
        idle_check(3);

        for (int n = 0; n < 16; n++) begin
            logic [31:0] a;
            bit w;
            a = $urandom;
            w = $urandom_range(0, 1) == 1;
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
            run(w, 0, 0, a, a & 32'hFFFF_FFE0, d, $urandom_range(0, 2), -1, 1, r);
        end
        idle_check(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
